// File: rtl/ats21_client_initiator.sv
// Host-side initiator for the ATS21 client request interface: queues A/B instruction
// pairs, sends each as two 16-bit beats, returns captured status, and latches alarm edges.
module ats21_client_initiator #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int STAT_WAIT  = 2,
    parameter int NUM_ALARMS = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_a,
    input  logic [31:0]           cmd_b,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_stat_a,
    output logic [1:0]            rsp_stat_b,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  req,
    input  logic                  ready,
    output logic [15:0]           ctrlA,
    output logic [15:0]           ctrlB,
    input  logic [1:0]            statA,
    input  logic [1:0]            statB,
    input  logic [NUM_ALARMS-1:0] data,
    input  logic [NUM_ALARMS-1:0] alarm_clr,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  alarm_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STAT_WAIT + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SC_ONE   = SW'(1);
    localparam logic [SW-1:0] SC_LAST  = SW'(STAT_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_RDY, S_BEAT_HI, S_BEAT_LO, S_WAIT_STAT, S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [63:0]             mem_q [FIFO_DEPTH];
    logic [63:0]             mem_d [FIFO_DEPTH];
    logic [63:0]             head;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    push, pop;
    logic [31:0]             hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [SW-1:0]           scnt_q, scnt_d;
    logic                    req_q, req_d;
    logic [15:0]             ctrl_a_q, ctrl_a_d, ctrl_b_q, ctrl_b_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [1:0]              rsp_stat_a_q, rsp_stat_a_d, rsp_stat_b_q, rsp_stat_b_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    busy_q, busy_d;
    logic [NUM_ALARMS-1:0]   data_prev_q, pend_q, pend_d;
    logic                    irq_q, irq_d;

    // cmd_ready is registered, so a pop in the full cycle cannot admit a push that cycle
    assign push = cmd_valid && cmd_ready_q;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cmd_a, cmd_b};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        cmd_ready_d = (count_d != CNT_FULL);
    end

    always_comb begin
        state_d       = state_q;
        hold_a_d      = hold_a_q;
        hold_b_d      = hold_b_q;
        timer_d       = timer_q;
        scnt_d        = scnt_q;
        rsp_stat_a_d  = 2'b00;
        rsp_stat_b_d  = 2'b00;
        rsp_timeout_d = 1'b0;
        case (state_q)
            S_IDLE: if (pop) begin
                hold_a_d = head[63:32];
                hold_b_d = head[31:0];
                state_d  = S_REQ;
            end
            S_REQ: begin
                timer_d = '0;
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (ready) begin
                    state_d = S_BEAT_HI;
                end else if (timer_q == TMR_LAST) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            S_BEAT_HI: state_d = S_BEAT_LO;
            S_BEAT_LO: begin
                scnt_d  = '0;
                state_d = S_WAIT_STAT;
            end
            S_WAIT_STAT: begin
                if (scnt_q == SC_LAST) begin
                    rsp_stat_a_d = statA;
                    rsp_stat_b_d = statB;
                    state_d      = S_RESP;
                end else begin
                    scnt_d = scnt_q + SC_ONE;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Output flops load the decode of the next state so they line up with it
        req_d       = (state_d == S_REQ);
        rsp_valid_d = (state_d == S_RESP);
        ctrl_a_d    = 16'h0000;
        ctrl_b_d    = 16'h0000;
        if (state_d == S_BEAT_HI) begin
            ctrl_a_d = hold_a_q[31:16];
            ctrl_b_d = hold_b_q[31:16];
        end else if (state_d == S_BEAT_LO) begin
            ctrl_a_d = hold_a_q[15:0];
            ctrl_b_d = hold_b_q[15:0];
        end
        busy_d = (state_d != S_IDLE) || (count_d != '0);

        // A fresh rising edge beats a same-cycle clear
        pend_d = (pend_q & ~alarm_clr) | (data & ~data_prev_q);
        irq_d  = |pend_d;
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cmd_ready_q   <= 1'b1;
            hold_a_q      <= '0;
            hold_b_q      <= '0;
            timer_q       <= '0;
            scnt_q        <= '0;
            req_q         <= 1'b0;
            ctrl_a_q      <= '0;
            ctrl_b_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_stat_a_q  <= '0;
            rsp_stat_b_q  <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            data_prev_q   <= '0;
            pend_q        <= '0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cmd_ready_q   <= cmd_ready_d;
            hold_a_q      <= hold_a_d;
            hold_b_q      <= hold_b_d;
            timer_q       <= timer_d;
            scnt_q        <= scnt_d;
            req_q         <= req_d;
            ctrl_a_q      <= ctrl_a_d;
            ctrl_b_q      <= ctrl_b_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_stat_a_q  <= rsp_stat_a_d;
            rsp_stat_b_q  <= rsp_stat_b_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            data_prev_q   <= data;
            pend_q        <= pend_d;
            irq_q         <= irq_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign req           = req_q;
    assign ctrlA         = ctrl_a_q;
    assign ctrlB         = ctrl_b_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_stat_a    = rsp_stat_a_q;
    assign rsp_stat_b    = rsp_stat_b_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = busy_q;
    assign alarm_pending = pend_q;
    assign alarm_irq     = irq_q;
endmodule

// File: tb/tb_ats21_client_initiator.sv
// Directed bench for ats21_client_initiator: a simple ATS21 ready responder plus
// negedge monitors logging req, responses and beat data against hand-computed values.
module tb_ats21_client_initiator;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0, reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic        rsp_valid, rsp_timeout, busy, req;
    logic [1:0]  rsp_stat_a, rsp_stat_b;
    logic        ready = 1'b0;
    logic [15:0] ctrlA, ctrlB;
    logic [1:0]  statA = 2'b00, statB = 2'b00;
    logic [23:0] data = '0, alarm_clr = '0, alarm_pending;
    logic        alarm_irq;

    ats21_client_initiator dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid), .rsp_stat_a(rsp_stat_a),
        .rsp_stat_b(rsp_stat_b), .rsp_timeout(rsp_timeout), .busy(busy), .req(req),
        .ready(ready), .ctrlA(ctrlA), .ctrlB(ctrlB), .statA(statA), .statB(statB),
        .data(data), .alarm_clr(alarm_clr), .alarm_pending(alarm_pending),
        .alarm_irq(alarm_irq)
    );

    always #5 clk = ~clk;

    int          cyc = 0, total = 0, bad = 0, stray = 0;
    bit          rdy_en = 0, rdy_tie = 0, rdy_edge = 0;
    int          req_log[$];
    int          rsp_idx[$];
    logic [4:0]  rsp_log[$];
    logic [31:0] beat_log[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, output int t);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
        for (int n = 0; n < 50 && !cmd_ready; n++) tick();
        tick();
        t = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int lim);
        for (int i = 0; i < lim && rsp_log.size() < n; i++) tick();
        chk("rsp_count", rsp_log.size(), n);
    endtask

    task automatic clear_logs();
        req_log.delete(); rsp_idx.delete(); rsp_log.delete(); beat_log.delete();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        rdy_edge = ready;
    end

    // ATS21 model: ready one cycle after req, or tied high
    initial begin
        logic r;
        forever begin
            @(negedge clk); r = req;
            @(posedge clk); #1; ready = rdy_tie | (rdy_en & r);
        end
    end

    // Indices are the edge at which a value is seen (visible just before edge cyc+1)
    initial begin
        bit waiting = 0, req_last = 0, hi_last = 0, in_hi, in_lo;
        forever begin
            @(negedge clk);
            if (req) req_log.push_back(cyc + 1);
            if (rsp_valid) begin
                rsp_log.push_back({rsp_stat_a, rsp_stat_b, rsp_timeout});
                rsp_idx.push_back(cyc + 1);
            end
            in_lo = hi_last;
            in_hi = waiting && rdy_edge;
            if (in_hi || rsp_valid || !reset) waiting = 0;
            if (req_last) waiting = 1;
            req_last = req;
            hi_last  = in_hi;
            if (in_hi || in_lo) beat_log.push_back({ctrlA, ctrlB});
            else if (ctrlA != 16'h0 || ctrlB != 16'h0) stray++;
        end
    end

    logic [31:0] pa[6], pb[6];

    initial begin
        int t0, t1, acc_low, i, nrsp, nreq;
        bit acc;

        // reset state
        repeat (3) tick();
        chk("rst_req", req, 0);
        chk("rst_ctrlA", ctrlA, 0);
        chk("rst_ctrlB", ctrlB, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp", {rsp_stat_a, rsp_stat_b, rsp_timeout}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pending", alarm_pending, 0);
        chk("rst_irq", alarm_irq, 0);
        reset = 1'b1;
        tick();

        // single transaction, ready one cycle after req
        clear_logs();
        rdy_en = 1; statA = 2'b01; statB = 2'b00;
        push(32'h2080_0005, 32'h0000_0000, t0);
        chk("t1_busy", busy, 1);
        wait_rsp(1, 40);
        chk("t1_req_cnt", req_log.size(), 1);
        if (req_log.size() > 0) chk("t1_req_at", req_log[0] - t0, 2);
        if (rsp_log.size() > 0) begin
            chk("t1_rsp_at", rsp_idx[0] - t0, 8);
            chk("t1_rsp", rsp_log[0], 5'b01_00_0);
        end
        chk("t1_beat_cnt", beat_log.size(), 2);
        if (beat_log.size() >= 2) begin
            chk("t1_beat_hi", beat_log[0], 32'h2080_0000);
            chk("t1_beat_lo", beat_log[1], 32'h0005_0000);
        end
        repeat (3) tick();

        // timeout, then the queued pair issues normally
        clear_logs();
        rdy_en = 0; statA = 2'b11; statB = 2'b11;
        push(32'h7777_8888, 32'h9999_AAAA, t0);
        push(32'hABCD_1234, 32'h5678_9ABC, t1);
        wait_rsp(1, 60);
        rdy_en = 1; statA = 2'b01; statB = 2'b01;
        chk("t2_req_pulse", req_log.size(), 1);
        if (rsp_log.size() > 0 && req_log.size() > 0) begin
            chk("t2_tmo_rsp", rsp_log[0], 5'b00_00_1);
            chk("t2_tmo_at", rsp_idx[0] - req_log[0], TIMEOUT + 1);
        end
        wait_rsp(2, 40);
        chk("t2_req_cnt", req_log.size(), 2);
        if (rsp_log.size() >= 2 && req_log.size() >= 2) begin
            chk("t2_b2b_req", req_log[1] - rsp_idx[0], 2);
            chk("t2_rsp2", rsp_log[1], 5'b01_01_0);
        end
        chk("t2_beat_cnt", beat_log.size(), 2);
        if (beat_log.size() >= 2) begin
            chk("t2_beat_hi", beat_log[0], 32'hABCD_5678);
            chk("t2_beat_lo", beat_log[1], 32'h1234_9ABC);
        end
        repeat (3) tick();

        // queue fill: P0 parked in WAIT_RDY while five pairs are offered
        clear_logs();
        rdy_en = 0; statA = 2'b10; statB = 2'b01;
        pa[0] = 32'h0F0F_1234; pb[0] = 32'h00FF_ABCD;
        for (int k = 1; k < 6; k++) begin
            pa[k] = 32'h1000_2000 + 32'(k) * 32'h0001_0001;
            pb[k] = 32'h3000_4000 + 32'(k) * 32'h0001_0001;
        end
        push(pa[0], pb[0], t0);
        i = 0; acc_low = -1;
        cmd_valid = 1'b1; cmd_a = pa[1]; cmd_b = pb[1];
        for (int n = 0; n < 100 && i < 5; n++) begin
            acc = cmd_ready;
            if (!cmd_ready && acc_low < 0) begin
                acc_low = i;
                rdy_tie = 1;
            end
            tick();
            if (acc) begin
                i++;
                if (i < 5) begin cmd_a = pa[i+1]; cmd_b = pb[i+1]; end
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk("t3_acc_before_full", acc_low, 4);
        wait_rsp(6, 200);
        chk("t3_req_cnt", req_log.size(), 6);
        for (int k = 0; k < rsp_log.size(); k++) chk("t3_rsp", rsp_log[k], 5'b10_01_0);
        chk("t3_beat_cnt", beat_log.size(), 12);
        for (int k = 0; k < 6; k++) begin
            if (beat_log.size() >= 2 * k + 2) begin
                chk("t3_beat_hi", beat_log[2*k],   {pa[k][31:16], pb[k][31:16]});
                chk("t3_beat_lo", beat_log[2*k+1], {pa[k][15:0],  pb[k][15:0]});
            end
        end
        rdy_tie = 0;
        repeat (3) tick();

        // alarm monitor
        data[3] = 1'b1;
        tick();
        chk("al_set3", alarm_pending, 24'h000008);
        chk("al_irq1", alarm_irq, 1);
        alarm_clr[3] = 1'b1;
        tick();
        alarm_clr[3] = 1'b0;
        chk("al_clr3", alarm_pending, 24'h0);
        chk("al_irq0", alarm_irq, 0);
        repeat (2) tick();
        chk("al_level_noreset", alarm_pending, 24'h0);
        data[3] = 1'b0;
        data[7] = 1'b1; alarm_clr[7] = 1'b1;
        tick();
        alarm_clr[7] = 1'b0;
        chk("al_set_wins", alarm_pending, 24'h000080);
        chk("al_irq7", alarm_irq, 1);
        alarm_clr[7] = 1'b1;
        tick();
        alarm_clr[7] = 1'b0; data[7] = 1'b0;
        chk("al_clr7", alarm_pending, 24'h0);
        repeat (2) tick();

        // reset during BEAT_LO drops the pair and the queue
        clear_logs();
        rdy_en = 1;
        push(32'hDEAD_BEEF, 32'hCAFE_F00D, t0);
        push(32'h1111_2222, 32'h3333_4444, t1);
        for (int n = 0; n < 10 && cyc < t0 + 4; n++) tick();
        chk("t5_beat_lo", {ctrlA, ctrlB}, 32'hBEEF_F00D);
        reset = 1'b0;
        tick();
        chk("t5_req", req, 0);
        chk("t5_ctrl", {ctrlA, ctrlB}, 0);
        chk("t5_cmd_ready", cmd_ready, 1);
        chk("t5_busy", busy, 0);
        tick();
        reset = 1'b1;
        nrsp = rsp_log.size(); nreq = req_log.size();
        repeat (30) tick();
        chk("t5_no_rsp", rsp_log.size(), nrsp);
        chk("t5_no_req", req_log.size(), nreq);

        chk("stray_ctrl", stray, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
